z80_bus_responder: RTL and testbench
====================================

Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with these ports: clk input 1 (rising-edge clock); rst input 1 (asynchronous active-high reset).
REQ-002 The bus ports SHALL be: addr_bus input 16 (CPU address); data_in input 8 (data bus as driven by CPU); data_out output 8 (read data); data_oe output 1 (enable for the external data-bus tristate).
REQ-003 The strobe ports SHALL be: MREQ_L, IORQ_L, RD_L, WR_L, M1_L, RFSH_L, each input 1, each active-low CPU strobe.
REQ-004 The handshake ports SHALL be: WAIT_L output 1 (wait request to CPU); INT_L output 1 (maskable interrupt request).
REQ-005 The peripheral ports SHALL be: int_req input 1 (single-cycle interrupt source pulse); port_in input 8 (readable input port); port_out output 8 (latched output port).
REQ-006 The parameters SHALL be: MEM_AW, default 13, RAM address width; MEM_WAIT, default 1, wait cycles per memory access; IO_WAIT, default 0, extra wait cycles per I/O access; IO_BASE, default 8'h10, base of the 4-port I/O window; VECTOR, default 8'hFF, interrupt-acknowledge byte.

Function
REQ-007 A memory request SHALL be decoded while MREQ_L=0, RFSH_L=1 and (RD_L=0 or WR_L=0); refresh cycles (RFSH_L=0) SHALL be ignored.
REQ-008 An I/O request SHALL be decoded while IORQ_L=0, M1_L=1 and (RD_L=0 or WR_L=0).
REQ-009 An interrupt acknowledge (IACK) SHALL be decoded while IORQ_L=0 and M1_L=0.
REQ-010 The FSM SHALL have the states IDLE, WAIT, ACCESS and HOLD.
REQ-011 IDLE SHALL go to WAIT on a decoded request, latching the address, the kind (MEM/IO/IACK) and the direction; when the wait count is 0 it SHALL go directly to ACCESS.
REQ-012 WAIT SHALL load its counter with MEM_WAIT (memory) or IO_WAIT (I/O; IACK uses 0), decrement it each cycle, and go to ACCESS when the count reaches 1.
REQ-013 WAIT_L SHALL be 0 exactly while the FSM is in WAIT, and 1 otherwise.
REQ-014 ACCESS SHALL last one cycle and then go to HOLD: a read captures the data into data_out; a write commits data_in to its target.
REQ-015 HOLD SHALL go to IDLE in the first cycle in which MREQ_L, IORQ_L, RD_L and WR_L are all 1.
REQ-016 data_oe SHALL be 1 from the cycle after ACCESS of a read or IACK, while RD_L=0 (IACK: while IORQ_L=0), and 0 otherwise, including during writes.
REQ-017 Memory SHALL be addressed by addr_bus[MEM_AW-1:0]; upper address bits SHALL be ignored (aliasing), and the address SHALL wrap from 2^MEM_AW-1 to 0.
REQ-018 The I/O port SHALL be addr_bus[7:0]; offsets from IO_BASE SHALL be: +0 port_out (read/write); +1 port_in (read-only; writes ignored); +2 scratch (read/write); +3 status, reading {7'b0, pending} (read-only).
REQ-019 An unmapped I/O read SHALL return 8'hFF, and an unmapped I/O write SHALL be ignored.
REQ-020 int_req=1 SHALL set pending, INT_L SHALL equal ~pending (registered), and IACK in ACCESS SHALL return VECTOR and clear pending.
REQ-021 When int_req and the IACK clear occur in the same cycle, set SHALL win and pending SHALL stay 1.
REQ-022 An abort (strobes deasserted while in WAIT) SHALL return the FSM to IDLE with no write and no data_oe.
REQ-023 Strobe changes during ACCESS or HOLD SHALL NOT re-trigger a request; a new request SHALL be accepted only from IDLE.

Reset
REQ-024 While rst=1, the block SHALL hold: state=IDLE, WAIT_L=1, INT_L=1, data_oe=0, data_out=8'h00, port_out=8'h00, scratch=8'h00, pending=0, wait counter=0.
REQ-025 A reset asserted mid-transaction SHALL abort the transaction, with no RAM write and WAIT_L=1 in the same cycle; RAM contents SHALL NOT be cleared.

Structure
REQ-026 The shared package z80_bus_pkg SHALL contain the FSM state enum, the request-kind enum (MEM/IO/IACK) and the I/O offset constants.
REQ-027 The RAM SHALL be the sub-module z80_sram: single-port, synchronous read with 1-cycle latency, synchronous write, and 2^MEM_AW x 8.

Verification
REQ-028 Memory write then read: write 8'hA5 to 16'h0123, then read 16'h0123 with MEM_WAIT=1 -> WAIT_L=0 for exactly 1 cycle, data_out=8'hA5, and data_oe=1 until RD_L rises.
REQ-029 Aliasing: write 8'h3C to 16'hE010 (MEM_AW=13) -> a read of 16'h0010 returns 8'h3C; a refresh cycle at 16'h0010 causes no WAIT_L and no data_oe.
REQ-030 I/O map: write 8'h5A to port 8'h10 -> port_out=8'h5A; port_in=8'hC3 -> a read of port 8'h11 gives 8'hC3; a read of port 8'h20 gives 8'hFF; a write to port 8'h11 is ignored.
REQ-031 Interrupt: int_req pulse -> INT_L=0 next cycle; a port 8'h13 read gives 8'h01; IACK returns 8'hFF and INT_L=1 afterwards; int_req coincident with the IACK clear leaves INT_L=0.
REQ-032 Abort and reset: with MEM_WAIT=3, RD_L/MREQ_L rising in the 2nd WAIT cycle -> IDLE, with no data_oe; rst=1 during a write's WAIT -> WAIT_L=1 immediately and the target byte is unchanged.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus responder.
// Holds the FSM states, the request kinds and the I/O window offsets.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_HOLD
  } state_e;

  typedef enum logic [1:0] {
    K_MEM,
    K_IO,
    K_IACK
  } kind_e;

  localparam logic [1:0] IO_OFS_PORT_OUT = 2'd0;
  localparam logic [1:0] IO_OFS_PORT_IN  = 2'd1;
  localparam logic [1:0] IO_OFS_SCRATCH  = 2'd2;
  localparam logic [1:0] IO_OFS_STATUS   = 2'd3;

endpackage

// File: rtl/z80_sram.sv
// Single-port 2^AW x 8 RAM with a registered read (one cycle of latency).
// It has no reset, so its contents survive a responder reset.
module z80_sram #(
  parameter int AW = 13
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus slave: RAM, a 4-port I/O window and one interrupt source.
// It inserts WAIT_L cycles, returns read data and latches writes.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int          MEM_AW   = 13,
  parameter int          MEM_WAIT = 1,
  parameter int          IO_WAIT  = 0,
  parameter logic [7:0]  IO_BASE  = 8'h10,
  parameter logic [7:0]  VECTOR   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic        MREQ_L,
  input  logic        IORQ_L,
  input  logic        RD_L,
  input  logic        WR_L,
  input  logic        M1_L,
  input  logic        RFSH_L,
  output logic        WAIT_L,
  output logic        INT_L,
  input  logic        int_req,
  input  logic [7:0]  port_in,
  output logic [7:0]  port_out
);

  localparam logic [7:0] LP_MEM_WAIT = 8'(MEM_WAIT);
  localparam logic [7:0] LP_IO_WAIT  = 8'(IO_WAIT);

  state_e      r_state;
  kind_e       r_kind;
  logic        r_write;
  logic [15:0] r_addr;
  logic [7:0]  r_cnt;
  logic [7:0]  r_data_out;
  logic [7:0]  r_port_out;
  logic [7:0]  r_scratch;
  logic        r_pending;
  logic        r_int_l;
  logic        r_wait_l;

  logic        w_rw;
  logic        w_mem_req;
  logic        w_io_req;
  logic        w_iack_req;
  logic        w_dec_valid;
  kind_e       w_dec_kind;
  logic [7:0]  w_dec_cnt;
  logic        w_still;
  logic [7:0]  w_io_ofs;
  logic        w_io_hit;
  logic [7:0]  w_io_rdata;
  logic [7:0]  w_access_rdata;
  logic [MEM_AW-1:0] w_ram_addr;
  logic        w_ram_we;
  logic [7:0]  w_ram_rdata;
  logic        w_iack_clr;
  logic        w_pending_nxt;
  logic        w_unused;

  assign w_rw       = ~RD_L | ~WR_L;
  assign w_mem_req  = ~MREQ_L & RFSH_L & w_rw;
  assign w_io_req   = ~IORQ_L & M1_L & w_rw;
  assign w_iack_req = ~IORQ_L & ~M1_L;

  // IACK outranks plain I/O, which outranks memory.
  always_comb begin
    w_dec_valid = 1'b1;
    w_dec_kind  = K_MEM;
    w_dec_cnt   = LP_MEM_WAIT;
    if (w_iack_req) begin
      w_dec_kind = K_IACK;
      w_dec_cnt  = 8'd0;
    end else if (w_io_req) begin
      w_dec_kind = K_IO;
      w_dec_cnt  = LP_IO_WAIT;
    end else if (!w_mem_req) begin
      w_dec_valid = 1'b0;
    end
  end

  always_comb begin
    case (r_kind)
      K_IO:    w_still = w_io_req;
      K_IACK:  w_still = w_iack_req;
      default: w_still = w_mem_req;
    endcase
  end

  // Offsets below IO_BASE wrap to large values and fall outside the window.
  assign w_io_ofs = r_addr[7:0] - IO_BASE;
  assign w_io_hit = (w_io_ofs[7:2] == 6'd0);

  always_comb begin
    w_io_rdata = 8'hFF;
    if (w_io_hit) begin
      case (w_io_ofs[1:0])
        IO_OFS_PORT_OUT: w_io_rdata = r_port_out;
        IO_OFS_PORT_IN:  w_io_rdata = port_in;
        IO_OFS_SCRATCH:  w_io_rdata = r_scratch;
        default:         w_io_rdata = {7'b0, r_pending};
      endcase
    end
  end

  always_comb begin
    case (r_kind)
      K_IO:    w_access_rdata = w_io_rdata;
      K_IACK:  w_access_rdata = VECTOR;
      default: w_access_rdata = w_ram_rdata;
    endcase
  end

  // The RAM sees the live bus address in IDLE so read data is ready by ACCESS even with zero waits.
  assign w_ram_addr = (r_state == ST_IDLE) ? addr_bus[MEM_AW-1:0] : r_addr[MEM_AW-1:0];
  assign w_ram_we   = (r_state == ST_ACCESS) && (r_kind == K_MEM) && r_write;

  z80_sram #(.AW(MEM_AW)) u_sram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (data_in),
    .o_rdata (w_ram_rdata)
  );

  assign w_iack_clr    = (r_state == ST_ACCESS) && (r_kind == K_IACK);
  assign w_pending_nxt = int_req | (r_pending & ~w_iack_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_kind     <= K_MEM;
      r_write    <= 1'b0;
      r_addr     <= 16'h0000;
      r_cnt      <= 8'd0;
      r_data_out <= 8'h00;
      r_port_out <= 8'h00;
      r_scratch  <= 8'h00;
      r_pending  <= 1'b0;
      r_int_l    <= 1'b1;
      r_wait_l   <= 1'b1;
    end else begin
      r_pending <= w_pending_nxt;
      r_int_l   <= ~w_pending_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_dec_valid) begin
            r_addr  <= addr_bus;
            r_kind  <= w_dec_kind;
            r_write <= ~WR_L;
            if (w_dec_cnt == 8'd0) begin
              r_state <= ST_ACCESS;
            end else begin
              r_state  <= ST_WAIT;
              r_wait_l <= 1'b0;
              r_cnt    <= w_dec_cnt;
            end
          end
        end
        ST_WAIT: begin
          if (!w_still) begin
            r_state  <= ST_IDLE;
            r_wait_l <= 1'b1;
            r_cnt    <= 8'd0;
          end else if (r_cnt <= 8'd1) begin
            r_state  <= ST_ACCESS;
            r_wait_l <= 1'b1;
            r_cnt    <= 8'd0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_ACCESS: begin
          r_state <= ST_HOLD;
          if (r_write) begin
            if ((r_kind == K_IO) && w_io_hit) begin
              case (w_io_ofs[1:0])
                IO_OFS_PORT_OUT: r_port_out <= data_in;
                IO_OFS_SCRATCH:  r_scratch  <= data_in;
                default: ;
              endcase
            end
          end else begin
            r_data_out <= w_access_rdata;
          end
        end
        default: begin
          if (MREQ_L && IORQ_L && RD_L && WR_L) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign data_oe  = (r_state == ST_HOLD) && !r_write &&
                    ((r_kind == K_IACK) ? ~IORQ_L : ~RD_L);
  assign data_out = r_data_out;
  assign port_out = r_port_out;
  assign WAIT_L   = r_wait_l;
  assign INT_L    = r_int_l;

  // Upper address bits alias by design.
  assign w_unused = ^{addr_bus, r_addr};

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: memory, I/O map, interrupts, abort and reset.
// A second instance with MEM_WAIT=3 covers the multi-cycle wait and abort path.
module tb_z80_bus_responder;

  logic        clk;
  logic        rst;
  logic [15:0] addr_bus;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        MREQ_L, IORQ_L, RD_L, WR_L, M1_L, RFSH_L;
  logic        WAIT_L, INT_L;
  logic        int_req;
  logic [7:0]  port_in;
  logic [7:0]  port_out;

  logic        MREQ_L3, RD_L3;
  logic [7:0]  unused_dout3;
  logic        data_oe3;
  logic        WAIT_L3;
  logic        unused_intl3;
  logic [7:0]  unused_pout3;

  int n_checks = 0;
  int n_pass   = 0;

  z80_bus_responder u_dut (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe),
    .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
    .M1_L(M1_L), .RFSH_L(RFSH_L), .WAIT_L(WAIT_L), .INT_L(INT_L),
    .int_req(int_req), .port_in(port_in), .port_out(port_out)
  );

  z80_bus_responder #(.MEM_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_in(data_in),
    .data_out(unused_dout3), .data_oe(data_oe3),
    .MREQ_L(MREQ_L3), .IORQ_L(IORQ_L), .RD_L(RD_L3), .WR_L(WR_L),
    .M1_L(M1_L), .RFSH_L(RFSH_L), .WAIT_L(WAIT_L3), .INT_L(unused_intl3),
    .int_req(int_req), .port_in(port_in), .port_out(unused_pout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // kind: 0 memory, 1 I/O, 2 interrupt acknowledge. Called #1 after a rising edge.
  task automatic bus_cycle(input int kind, input logic wr, input logic [15:0] a,
                           input logic [7:0] d, output logic [7:0] rd, output int wcyc,
                           output logic oe_acc, output logic oe_hold, output logic oe_rel);
    addr_bus = a;
    data_in  = d;
    MREQ_L   = (kind != 0);
    IORQ_L   = (kind == 0);
    M1_L     = (kind != 2);
    RD_L     = (kind == 2) | wr;
    WR_L     = (kind == 2) | ~wr;
    wcyc     = 0;
    @(posedge clk); #1;
    while (WAIT_L === 1'b0 && wcyc < 16) begin
      wcyc++;
      @(posedge clk); #1;
    end
    oe_acc = data_oe;
    @(posedge clk); #1;
    rd      = data_out;
    oe_hold = data_oe;
    @(posedge clk); #1;
    oe_hold = oe_hold & data_oe;
    MREQ_L = 1'b1; IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; M1_L = 1'b1;
    #1;
    oe_rel = data_oe;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] rd;
    int         wc;
    logic       oa, oh, orl;
    logic       bad_w, bad_o;

    rst = 1'b1; addr_bus = 16'h0000; data_in = 8'h00;
    MREQ_L = 1'b1; IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; M1_L = 1'b1; RFSH_L = 1'b1;
    MREQ_L3 = 1'b1; RD_L3 = 1'b1; int_req = 1'b0; port_in = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_wait_l",   16'(WAIT_L),   16'h1);
    chk("rst_int_l",    16'(INT_L),    16'h1);
    chk("rst_data_oe",  16'(data_oe),  16'h0);
    chk("rst_data_out", 16'(data_out), 16'h00);
    chk("rst_port_out", 16'(port_out), 16'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    // Memory write then read back with one wait cycle
    bus_cycle(0, 1'b1, 16'h0123, 8'hA5, rd, wc, oa, oh, orl);
    chk("mem_wr_waits", 16'(wc), 16'd1);
    chk("mem_wr_no_oe", 16'(oh), 16'h0);
    bus_cycle(0, 1'b0, 16'h0123, 8'h00, rd, wc, oa, oh, orl);
    chk("mem_rd_waits",  16'(wc),  16'd1);
    chk("mem_rd_data",   16'(rd),  16'h00A5);
    chk("mem_rd_oe_acc", 16'(oa),  16'h0);
    chk("mem_rd_oe",     16'(oh),  16'h1);
    chk("mem_rd_oe_rel", 16'(orl), 16'h0);

    // Aliasing of upper address bits and wrap at the top of RAM
    bus_cycle(0, 1'b1, 16'hE010, 8'h3C, rd, wc, oa, oh, orl);
    bus_cycle(0, 1'b0, 16'h0010, 8'h00, rd, wc, oa, oh, orl);
    chk("alias_rd", 16'(rd), 16'h003C);
    bus_cycle(0, 1'b1, 16'h1FFF, 8'h5E, rd, wc, oa, oh, orl);
    bus_cycle(0, 1'b0, 16'hFFFF, 8'h00, rd, wc, oa, oh, orl);
    chk("wrap_rd", 16'(rd), 16'h005E);

    // Refresh cycle must be ignored
    addr_bus = 16'h0010; MREQ_L = 1'b0; RFSH_L = 1'b0; RD_L = 1'b0;
    bad_w = 1'b0; bad_o = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (WAIT_L !== 1'b1) bad_w = 1'b1;
      if (data_oe !== 1'b0) bad_o = 1'b1;
    end
    MREQ_L = 1'b1; RFSH_L = 1'b1; RD_L = 1'b1;
    @(posedge clk); #1;
    chk("rfsh_wait_l", 16'(bad_w), 16'h0);
    chk("rfsh_oe",     16'(bad_o), 16'h0);

    // I/O window
    bus_cycle(1, 1'b1, 16'h0010, 8'h5A, rd, wc, oa, oh, orl);
    chk("io_wr_waits", 16'(wc),       16'd0);
    chk("io_port_out", 16'(port_out), 16'h005A);
    port_in = 8'hC3;
    bus_cycle(1, 1'b0, 16'h0011, 8'h00, rd, wc, oa, oh, orl);
    chk("io_port_in", 16'(rd), 16'h00C3);
    bus_cycle(1, 1'b0, 16'h0020, 8'h00, rd, wc, oa, oh, orl);
    chk("io_unmapped", 16'(rd), 16'h00FF);
    bus_cycle(1, 1'b1, 16'h0011, 8'h77, rd, wc, oa, oh, orl);
    chk("io_wr_ro_port_out", 16'(port_out), 16'h005A);
    bus_cycle(1, 1'b0, 16'h0011, 8'h00, rd, wc, oa, oh, orl);
    chk("io_wr_ro_port_in", 16'(rd), 16'h00C3);
    bus_cycle(1, 1'b1, 16'h0012, 8'h66, rd, wc, oa, oh, orl);
    bus_cycle(1, 1'b0, 16'h0012, 8'h00, rd, wc, oa, oh, orl);
    chk("io_scratch", 16'(rd), 16'h0066);
    bus_cycle(1, 1'b0, 16'h0010, 8'h00, rd, wc, oa, oh, orl);
    chk("io_port_out_rd", 16'(rd), 16'h005A);

    // Interrupt request, status read and acknowledge
    int_req = 1'b1;
    @(posedge clk); #1;
    int_req = 1'b0;
    chk("int_l_set", 16'(INT_L), 16'h0);
    bus_cycle(1, 1'b0, 16'h0013, 8'h00, rd, wc, oa, oh, orl);
    chk("status_pending", 16'(rd), 16'h0001);
    bus_cycle(2, 1'b0, 16'h0000, 8'h00, rd, wc, oa, oh, orl);
    chk("iack_vector", 16'(rd),    16'h00FF);
    chk("iack_oe",     16'(oh),    16'h1);
    chk("iack_int_l",  16'(INT_L), 16'h1);
    bus_cycle(1, 1'b0, 16'h0013, 8'h00, rd, wc, oa, oh, orl);
    chk("status_clear", 16'(rd), 16'h0000);

    // New request coincident with the acknowledge clear keeps INT_L low
    int_req = 1'b1;
    @(posedge clk); #1;
    int_req = 1'b0;
    M1_L = 1'b0; IORQ_L = 1'b0;
    @(posedge clk); #1;
    int_req = 1'b1;
    @(posedge clk); #1;
    int_req = 1'b0;
    chk("coinc_int_l",  16'(INT_L),    16'h0);
    chk("coinc_vector", 16'(data_out), 16'h00FF);
    M1_L = 1'b1; IORQ_L = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("coinc_int_l_after", 16'(INT_L), 16'h0);
    bus_cycle(2, 1'b0, 16'h0000, 8'h00, rd, wc, oa, oh, orl);
    chk("coinc_iack_int_l", 16'(INT_L), 16'h1);

    // Abort in the second wait cycle of the MEM_WAIT=3 instance
    addr_bus = 16'h0040; MREQ_L3 = 1'b0; RD_L3 = 1'b0;
    @(posedge clk); #1;
    chk("abort_wait1", 16'(WAIT_L3), 16'h0);
    @(posedge clk); #1;
    chk("abort_wait2", 16'(WAIT_L3), 16'h0);
    MREQ_L3 = 1'b1; RD_L3 = 1'b1;
    bad_w = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (WAIT_L3 !== 1'b1 || data_oe3 !== 1'b0) bad_w = 1'b1;
    end
    chk("abort_idle", 16'(bad_w), 16'h0);
    MREQ_L3 = 1'b0; RD_L3 = 1'b0; wc = 0;
    @(posedge clk); #1;
    while (WAIT_L3 === 1'b0 && wc < 16) begin
      wc++;
      @(posedge clk); #1;
    end
    chk("wait3_count", 16'(wc), 16'd3);
    @(posedge clk); #1;
    chk("wait3_oe", 16'(data_oe3), 16'h1);
    MREQ_L3 = 1'b1; RD_L3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset during a write's wait cycle
    bus_cycle(0, 1'b1, 16'h0200, 8'h11, rd, wc, oa, oh, orl);
    addr_bus = 16'h0200; data_in = 8'h99; MREQ_L = 1'b0; WR_L = 1'b0;
    @(posedge clk); #1;
    chk("rstw_in_wait", 16'(WAIT_L), 16'h0);
    rst = 1'b1;
    #1;
    chk("rstw_wait_l", 16'(WAIT_L), 16'h1);
    MREQ_L = 1'b1; WR_L = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstw_port_out", 16'(port_out), 16'h0000);
    bus_cycle(0, 1'b0, 16'h0200, 8'h00, rd, wc, oa, oh, orl);
    chk("rstw_target", 16'(rd), 16'h0011);
    bus_cycle(0, 1'b0, 16'h0123, 8'h00, rd, wc, oa, oh, orl);
    chk("rstw_ram_kept", 16'(rd), 16'h00A5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
